// File: rtl/multiword_prefix_add_seq.sv
// multiword_prefix_add_seq
//   Multi-cycle wide adder/subtractor. A full-width operand pair is accepted
//   on a valid/ready handshake, then added one CW-bit slice per cycle (LSB
//   slice first) through a Sklansky parallel-prefix chunk adder, with each
//   chunk's carry-out chained into the next chunk's carry-in. The assembled
//   sum, the final carry and the signed overflow flag are held on a
//   valid/ready output port until taken.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set (IDLE only)
//   a, b       N-bit operands, N = CW*NCH
//   cin        carry-in for add, ignored when sub=1
//   sub        1 = a - b, computed as a + ~b + 1
//   out_valid  result valid (DONE only)
//   out_ready  downstream takes the result
//   sum        N-bit result
//   cout       carry-out of the MSB chunk (for sub, 1 = no borrow)
//   ovf        two's-complement signed overflow of the N-bit operation

// Sklansky prefix adder for one chunk. The carry-in is folded into the
// bit-0 generate, so the final group generate of bit i is directly the carry
// out of bit i and no separate carry-in post-processing is needed.
module sklansky_add #(
  parameter int W = 15
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int LV = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0] g, p, gg, pp, gn, pn;
  logic [W:0]   carries;

  // Each level l lets every bit with bit l of its index set absorb the group
  // ending just below its 2^l-aligned block boundary (the Sklansky fan-out).
  always_comb begin
    g     = x & y;
    p     = x ^ y;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & ci);
    gn    = gg;
    pn    = pp;
    for (int l = 0; l < LV; l++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < W; i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
          pn[i] = pp[i] & pp[((i >> l) << l) - 1];
        end
      end
      gg = gn;
      pp = pn;
    end
    carries = {gg, ci};
    s       = p ^ carries[W-1:0];
    co      = carries[W];
  end

endmodule

module multiword_prefix_add_seq #(
  parameter int CW  = 15,
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW*NCH-1:0] a,
  input  logic [CW*NCH-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW*NCH-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int N  = CW * NCH;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [N-1:0]    a_q, b_q;
  logic            cy;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   a_slice, b_slice, csum;
  logic            ccout;
  logic            last;

  assign a_slice = a_q[int'(idx)*CW +: CW];
  assign b_slice = b_q[int'(idx)*CW +: CW];
  assign last    = (idx == IW'(NCH - 1));

  sklansky_add #(.W(CW)) u_chunk (
    .x  (a_slice),
    .y  (b_slice),
    .ci (cy),
    .s  (csum),
    .co (ccout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs; both handshakes depend on state only,
  // so there is no combinational path from in_valid or out_ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand staging and slice-by-slice result assembly. B is stored already
  // inverted for subtraction so the chunk adder only ever adds. The overflow
  // flag uses the stored (possibly inverted) B MSB together with the MSB
  // chunk's sum bit on the final RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      cy   <= 1'b0;
      idx  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
            cy  <= sub ? 1'b1 : cin;
            idx <= '0;
          end
        end
        RUN: begin
          sum[int'(idx)*CW +: CW] <= csum;
          cy <= ccout;
          if (last) begin
            cout <= ccout;
            ovf  <= (a_q[N-1] == b_q[N-1]) && (csum[CW-1] != a_q[N-1]);
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_prefix_add_seq.sv
// tb_multiword_prefix_add_seq
//   Self-checking bench: directed cases (carry ripple, subtract, overflow,
//   carry-in, backpressure, mid-run reset) followed by randomized traffic
//   compared against a plain N-bit arithmetic reference model.
module tb_multiword_prefix_add_seq;

  localparam int CW  = 15;
  localparam int NCH = 4;
  localparam int N   = CW * NCH;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout, ovf;

  int checks   = 0;
  int failures = 0;

  multiword_prefix_add_seq #(.CW(CW), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: plain N-bit arithmetic. Result packed as {ovf, cout, sum}.
  function automatic logic [N+1:0] refModel(input logic [N-1:0] ai,
                                            input logic [N-1:0] bi,
                                            input logic ci, input logic si);
    logic [N-1:0] bp;
    logic [N:0]   full;
    logic         o;
    bp   = si ? ~bi : bi;
    full = {1'b0, ai} + {1'b0, bp} + {{N{1'b0}}, (si ? 1'b1 : ci)};
    o    = (ai[N-1] == bp[N-1]) && (full[N-1] != ai[N-1]);
    return {o, full[N], full[N-1:0]};
  endfunction

  function automatic logic [N-1:0] randOperand();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       return {1'b0, {(N-1){1'b1}}};
      1:       return {1'b1, {(N-1){1'b0}}};
      2:       return {N{1'b1}};
      3:       return N'($urandom_range(0, 7));
      default: return r[N-1:0];
    endcase
  endfunction

  // Present one operand set, wait for the accept, then count cycles to
  // out_valid (bounded). Leaves the result held in DONE.
  task automatic applyStimulus(input string tag, input logic [N-1:0] ai,
                               input logic [N-1:0] bi, input logic ci,
                               input logic si);
    int lat;
    logic got;
    @(negedge clk);
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1; out_ready = 1'b0;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_valid"}, 64'(got), 64'd1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NCH));
  endtask

  task automatic checkResult(input string tag, input logic [N-1:0] es,
                             input logic ec, input logic eo);
    checkOutput({tag, "_sum"}, 64'(sum), 64'(es));
    checkOutput({tag, "_cout"}, 64'(cout), 64'(ec));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic takeResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [N+1:0] expq[$];

  initial begin
    logic [N+1:0] e;
    logic [N-1:0] hs;
    logic         hc, ho;
    int sent, received, gap, cyc;
    logic last_acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // Carry ripples through all four chunks.
    applyStimulus("t1", 60'hFFF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0);
    checkResult("t1", 60'd0, 1'b1, 1'b0);
    takeResult();

    // Subtract with borrow.
    applyStimulus("t2", 60'd5, 60'd7, 1'b0, 1'b1);
    checkResult("t2", 60'hFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    takeResult();

    // Signed overflow.
    applyStimulus("t3a", 60'h7FF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0);
    checkResult("t3a", 60'h800_0000_0000_0000, 1'b0, 1'b1);
    takeResult();

    // Carry-in only.
    applyStimulus("t3b", 60'd0, 60'd0, 1'b1, 1'b0);
    checkResult("t3b", 60'd1, 1'b0, 1'b0);
    takeResult();

    // Backpressure: result held for 10 cycles, no new accept.
    applyStimulus("t4", 60'h123_4567_89AB_CDEF, 60'h0FE_DCBA_9876_5432, 1'b1, 1'b0);
    e = refModel(60'h123_4567_89AB_CDEF, 60'h0FE_DCBA_9876_5432, 1'b1, 1'b0);
    hs = sum; hc = cout; ho = ovf;
    checkResult("t4", e[N-1:0], e[N], e[N+1]);
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("t4_hold_sum", 64'(sum), 64'(hs));
      checkOutput("t4_hold_flags", 64'({cout, ovf}), 64'({hc, ho}));
      checkOutput("t4_hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("t4_hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    takeResult();
    checkOutput("t4_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t4_release_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of RUN (idx=2).
    @(negedge clk);
    a = 60'hABC_DEF0_1234_5678; b = 60'h111_1111_1111_1111; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t5_sum", 64'(sum), 64'd0);
    rst = 1'b0;
    applyStimulus("t5b", 60'd3, 60'd4, 1'b0, 1'b0);
    checkResult("t5b", 60'd7, 1'b0, 1'b0);
    takeResult();

    // Randomized traffic with random input gaps and output backpressure.
    sent = 0; received = 0; gap = 0; cyc = 0; last_acc = 1'b0;
    while (received < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      // Output side: decide readiness and check what will be taken.
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("rand_unexpected_result", 64'(expq.size()), 64'd1);
        end else begin
          e = expq.pop_front();
          checkOutput("rand_sum", 64'(sum), 64'(e[N-1:0]));
          checkOutput("rand_cout", 64'(cout), 64'(e[N]));
          checkOutput("rand_ovf", 64'(ovf), 64'(e[N+1]));
        end
        received++;
      end
      // Input side: drop after accept, wait a random gap, present new data.
      if (last_acc) begin
        in_valid = 1'b0;
        last_acc = 1'b0;
        gap = $urandom_range(0, 3);
      end
      if (!in_valid) begin
        if (gap > 0) gap--;
        else if (sent < 1000) begin
          a = randOperand(); b = randOperand();
          cin = $urandom_range(0, 1) == 1; sub = $urandom_range(0, 1) == 1;
          in_valid = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(refModel(a, b, cin, sub));
        sent++;
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("rand_received", 64'(received), 64'd1000);
    checkOutput("rand_sent", 64'(sent), 64'd1000);
    checkOutput("rand_leftover", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
